// File: rtl/bch15_7_decoder.sv
// bch15_7_decoder: serial-search BCH(15,7) decoder correcting up to two bit errors
module bch15_7_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_data,
  output logic [1:0]  out_err_cnt,
  output logic        out_uncorr
);
  typedef enum logic [1:0] {IDLE, SEARCH, OUT} state_t;
  localparam logic [7:0] cols [15] = '{8'hD1, 8'h73, 8'hE6, 8'h1D, 8'h3A, 8'h74, 8'hE8,
                                       8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  state_t      state;
  logic [6:0]  data;
  logic [7:0]  syn;
  logic [3:0]  j;
  logic        done;
  logic [7:0]  x;
  logic [3:0]  k;
  logic        single, dbl, hit;
  logic [6:0]  fix;
  function automatic logic [7:0] parity(input logic [6:0] d);
    return {d[0] ^ d[2] ^ d[6],
            d[0] ^ d[1] ^ d[2] ^ d[5] ^ d[6],
            d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[6],
            d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[5],
            d[3] ^ d[4] ^ d[6],
            d[2] ^ d[3] ^ d[5],
            d[1] ^ d[2] ^ d[4],
            d[0] ^ d[1] ^ d[3]};
  endfunction
  // One candidate position j per cycle; the partner k is found by a parallel column compare.
  always_comb begin
    x = syn ^ cols[j];
    dbl = 1'b0;
    k = 4'd0;
    for (int i = 0; i < 15; i++)
      if (!dbl && 4'(i) != j && x == cols[i]) begin
        dbl = 1'b1;
        k = 4'(i);
      end
    single = x == 8'h0;
    hit = syn == 8'h0 || single || dbl;
    fix = (syn == 8'h0) ? 7'h0 :
          ((j < 4'd7) ? 7'h1 << j : 7'h0) ^ ((dbl && k < 4'd7) ? 7'h1 << k : 7'h0);
  end
  // The result is captured one edge before OUT is entered, giving the E0+2+j latency.
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      data <= 7'h0;
      syn <= 8'h0;
      j <= 4'd0;
      done <= 1'b0;
      out_data <= 7'h0;
      out_err_cnt <= 2'd0;
      out_uncorr <= 1'b0;
    end else
      case (state)
        IDLE:
          if (in_valid) begin
            data <= in_code[6:0];
            syn <= in_code[14:7] ^ parity(in_code[6:0]);
            j <= 4'd0;
            done <= 1'b0;
            in_ready <= 1'b0;
            state <= SEARCH;
          end
        SEARCH:
          if (done) begin
            out_valid <= 1'b1;
            state <= OUT;
          end else if (hit) begin
            out_data <= data ^ fix;
            out_err_cnt <= (syn == 8'h0) ? 2'd0 : single ? 2'd1 : 2'd2;
            out_uncorr <= 1'b0;
            done <= 1'b1;
          end else if (j == 4'd14) begin
            out_data <= data;
            out_err_cnt <= 2'd0;
            out_uncorr <= 1'b1;
            done <= 1'b1;
          end else
            j <= j + 4'd1;
        OUT:
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_bch15_7_decoder.sv
// tb_bch15_7_decoder: directed vectors, corner sequences and random words against an error-pattern model
module tb_bch15_7_decoder;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_uncorr;
  logic [14:0] in_code;
  logic [6:0]  out_data;
  logic [1:0]  out_err_cnt;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  bch15_7_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err_cnt(out_err_cnt), .out_uncorr(out_uncorr)
  );

  localparam logic [7:0] hcol [15] = '{8'hD1, 8'h73, 8'hE6, 8'h1D, 8'h3A, 8'h74, 8'hE8,
                                       8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  typedef struct {
    logic [14:0] code;
    logic [6:0]  data;
    logic [1:0]  cnt;
    logic        uncorr;
    int          lat;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hsyn(input logic [14:0] c);
    logic [7:0] s = 8'h0;
    for (int i = 0; i < 15; i++) if (c[i]) s ^= hcol[i];
    return s;
  endfunction

  // Find the unique error pattern of weight <= 2 matching the syndrome, lowest position first.
  function automatic vec_t model(input logic [14:0] c);
    vec_t v;
    logic [7:0] s = hsyn(c);
    logic [14:0] e, fixed;
    v.code = c; v.data = c[6:0]; v.cnt = 2'd0; v.uncorr = 1'b1; v.lat = 16;
    if (s == 8'h0) begin
      v.uncorr = 1'b0; v.lat = 2;
      return v;
    end
    for (int a = 0; a < 15; a++)
      for (int b = a; b < 15; b++) begin
        e = (15'h1 << a) | (15'h1 << b);
        if (hsyn(e) == s) begin
          fixed = c ^ e;
          v.data = fixed[6:0]; v.cnt = (a == b) ? 2'd1 : 2'd2; v.uncorr = 1'b0; v.lat = 2 + a;
          return v;
        end
      end
    return v;
  endfunction

  // Called at posedge+1 with the DUT idle; hold = OUT cycles with out_ready low.
  task automatic decode(input logic [14:0] c, input int hold, output vec_t got);
    in_code = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_code = 15'($urandom);
    got.code = c; got.lat = 0;
    while (!out_valid && got.lat < 40) begin
      @(posedge clk); #1;
      got.lat++;
    end
    got.data = out_data; got.cnt = out_err_cnt; got.uncorr = out_uncorr;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_code = 15'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_data", out_data, got.data);
      check("hold_cnt", out_err_cnt, got.cnt);
      check("hold_uncorr", out_uncorr, got.uncorr);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
  endtask

  task automatic compare(input string name, input vec_t got, input vec_t exp);
    check({name, "_data"}, got.data, exp.data);
    check({name, "_cnt"}, got.cnt, exp.cnt);
    check({name, "_uncorr"}, got.uncorr, exp.uncorr);
    check({name, "_lat"}, got.lat, exp.lat);
  endtask

  initial begin
    vec_t got, exp;
    logic [6:0] d;
    logic [14:0] c;
    int seen;
    vecs[0] = '{15'h6881, 7'h01, 2'd0, 1'b0, 2};
    vecs[1] = '{15'h6880, 7'h01, 2'd1, 1'b0, 2};
    vecs[2] = '{15'h0408, 7'h00, 2'd2, 1'b0, 5};
    vecs[3] = '{15'h000B, 7'h0B, 2'd0, 1'b1, 16};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_code = 15'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 7'h0);
    check("rst_cnt", out_err_cnt, 2'd0);
    check("rst_uncorr", out_uncorr, 1'b0);

    foreach (vecs[i]) begin
      decode(vecs[i].code, 0, got);
      compare($sformatf("vec%0d", i), got, vecs[i]);
    end

    decode(15'h0408, 3, got);
    compare("backpressure", got, vecs[2]);
    decode(15'h6880, 0, got);
    compare("after_bp", got, vecs[1]);

    in_code = 15'h000B; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 7'h0);
    check("midrst_uncorr", out_uncorr, 1'b0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);
    decode(15'h6881, 0, got);
    compare("after_rst", got, vecs[0]);

    for (int n = 0; n < 200; n++) begin
      int mode = $urandom_range(0, 4);
      d = 7'($urandom);
      c = {hsyn({8'h0, d}), d};
      for (int f = 0; f < mode && mode < 4; f++) c ^= 15'h1 << $urandom_range(0, 14);
      if (mode == 4) c = 15'($urandom);
      exp = model(c);
      decode(c, $urandom_range(0, 1), got);
      compare($sformatf("rand_%04h", c), got, exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
